// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// No logic of its own; consumed by the FSM top and its output decoder.
// Encodings match the datapath mux select wiring one-for-one.
package mips_ctrl_pkg;

  // FSM state encoding; the numeric values are visible on state_dbg.
  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEMADR  = 4'd2,
    ST_MEMRD   = 4'd3,
    ST_MEMWB   = 4'd4,
    ST_MEMWR   = 4'd5,
    ST_RTYPEEX = 4'd6,
    ST_RTYPEWB = 4'd7,
    ST_BEQEX   = 4'd8,
    ST_ADDIEX  = 4'd9,
    ST_ADDIWB  = 4'd10,
    ST_JEX     = 4'd11
  } state_e;

  // Supported opcodes (instr[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // ALU operation select.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B-operand select.
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source select.
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Complete control word presented to the datapath.
  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal_op;
  } ctrl_t;

  // True for every opcode the FSM knows how to sequence.
  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_J)  || (op == OP_BEQ) ||
           (op == OP_ADDI)  || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Output decoder: maps current FSM state (plus mem_ready in FETCH) to the control word.
// Latency: purely combinational, zero cycles.
// Backpressure: mem_ready only gates the FETCH-time IR/PC loads; stalls come from the FSM.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_e state_i,
  input  logic   mem_ready_i,
  input  logic   op_legal_i,
  output ctrl_t  ctrl_o
);

  // Moore decode of the control word; FETCH loads IR/PC only when the fetch completes.
  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      ST_FETCH: begin
        ctrl_o.iord      = 1'b0;
        ctrl_o.alu_src_a = 1'b0;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_src    = PCSRC_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      ST_DECODE: begin
        // Precompute the branch target while the opcode is decoded.
        ctrl_o.alu_src_a  = 1'b0;
        ctrl_o.alu_src_b  = SRCB_IMM_SH2;
        ctrl_o.alu_op     = ALUOP_ADD;
        ctrl_o.illegal_op = ~op_legal_i;
      end
      ST_MEMADR, ST_ADDIEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      ST_MEMRD: begin
        ctrl_o.iord = 1'b1;
      end
      ST_MEMWR: begin
        // Write strobe stays up for the whole state, including stall cycles.
        ctrl_o.iord      = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      ST_MEMWB: begin
        ctrl_o.reg_dst    = 1'b0;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
      end
      ST_RTYPEEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_REG;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      ST_RTYPEWB: begin
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.mem_to_reg = 1'b0;
        ctrl_o.reg_write  = 1'b1;
      end
      ST_ADDIWB: begin
        ctrl_o.reg_dst    = 1'b0;
        ctrl_o.mem_to_reg = 1'b0;
        ctrl_o.reg_write  = 1'b1;
      end
      ST_BEQEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_REG;
        ctrl_o.alu_op    = ALUOP_SUB;
        ctrl_o.pc_src    = PCSRC_ALUOUT;
        ctrl_o.branch    = 1'b1;
      end
      ST_JEX: begin
        ctrl_o.pc_src   = PCSRC_JUMP;
        ctrl_o.pc_write = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing and datapath selects.
// Latency: outputs are combinational from the state register (plus mem_ready in FETCH).
// Backpressure: FETCH, MEMRD and MEMWR hold while mem_ready is low (unless MEM_WAIT_EN=0).
module mips_mc_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  state_e state_q, state_d;
  logic   mem_rdy;
  logic   op_legal;
  ctrl_t  ctrl;

  // With waits disabled the memory is assumed to complete every access in one cycle.
  assign mem_rdy  = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign op_legal = op_supported(opcode);

  // State register; reset lands in FETCH asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; opcode only matters in DECODE and MEMADR.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FETCH:  if (mem_rdy) state_d = ST_DECODE;
      ST_DECODE: begin
        unique case (opcode)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYPE:     state_d = ST_RTYPEEX;
          OP_BEQ:       state_d = ST_BEQEX;
          OP_ADDI:      state_d = ST_ADDIEX;
          OP_J:         state_d = ST_JEX;
          default:      state_d = ST_FETCH;
        endcase
      end
      ST_MEMADR: begin
        if (opcode == OP_LW)      state_d = ST_MEMRD;
        else if (opcode == OP_SW) state_d = ST_MEMWR;
        else                      state_d = ST_FETCH;
      end
      ST_MEMRD:   if (mem_rdy) state_d = ST_MEMWB;
      ST_MEMWR:   if (mem_rdy) state_d = ST_FETCH;
      ST_RTYPEEX: state_d = ST_RTYPEWB;
      ST_ADDIEX:  state_d = ST_ADDIWB;
      ST_MEMWB, ST_RTYPEWB, ST_ADDIWB, ST_BEQEX, ST_JEX: state_d = ST_FETCH;
      default:    state_d = ST_FETCH;
    endcase
  end

  mips_ctrl_outdec u_outdec (
    .state_i     (state_q),
    .mem_ready_i (mem_rdy),
    .op_legal_i  (op_legal),
    .ctrl_o      (ctrl)
  );

  // Strobes are gated by rst_n so nothing fires while reset is held,
  // even though FETCH would otherwise follow mem_ready.
  assign ir_write   = ctrl.ir_write  & rst_n;
  assign pc_write   = ctrl.pc_write  & rst_n;
  assign mem_write  = ctrl.mem_write & rst_n;
  assign reg_write  = ctrl.reg_write & rst_n;
  assign branch     = ctrl.branch    & rst_n;
  assign iord       = ctrl.iord;
  assign pc_src     = ctrl.pc_src;
  assign alu_op     = ctrl.alu_op;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign illegal_op = ctrl.illegal_op;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: directed per-cycle vectors with expected control words.
// Driver pushes the expected word for each cycle; a negedge monitor pops and compares.
// Covers reset, every opcode, stalls in FETCH/MEMRD/MEMWR and mid-instruction reset.
module tb_mips_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'h3F;
  logic       mem_ready = 1'b1;
  logic       iord, mem_write, ir_write, pc_write, branch;
  logic [1:0] pc_src, alu_op, alu_src_b;
  logic       alu_src_a, reg_dst, mem_to_reg, reg_write, illegal_op;
  logic [3:0] state_dbg;

  int total = 0;
  int bad = 0;

  logic [19:0] exp_q[$];
  string       name_q[$];

  mips_mc_ctrl #(.MEM_WAIT_EN(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .iord       (iord),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .branch     (branch),
    .pc_src     (pc_src),
    .alu_op     (alu_op),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .illegal_op (illegal_op),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  // Expected control word for a state, taken from the per-state output table.
  // Layout: {state, iord, mem_write, ir_write, pc_write, branch, pc_src,
  //          alu_op, alu_src_a, alu_src_b, reg_dst, mem_to_reg, reg_write, illegal_op}
  function automatic logic [19:0] exp_vec(input logic [3:0] st, input logic mr,
                                          input logic rn, input logic ill);
    logic       io, mw, irw, pcw, br, sa, rd, mtr, rw;
    logic [1:0] ps, ao, sb;
    io = 0; mw = 0; irw = 0; pcw = 0; br = 0; sa = 0; rd = 0; mtr = 0; rw = 0;
    ps = 2'b00; ao = 2'b00; sb = 2'b00;
    case (st)
      4'd0:       begin sb = 2'b01; irw = mr; pcw = mr; end
      4'd1:       begin sb = 2'b11; end
      4'd2, 4'd9: begin sa = 1; sb = 2'b10; end
      4'd3:       begin io = 1; end
      4'd4:       begin mtr = 1; rw = 1; end
      4'd5:       begin io = 1; mw = 1; end
      4'd6:       begin sa = 1; sb = 2'b00; ao = 2'b10; end
      4'd7:       begin rd = 1; rw = 1; end
      4'd8:       begin sa = 1; ao = 2'b01; ps = 2'b01; br = 1; end
      4'd10:      begin rw = 1; end
      4'd11:      begin ps = 2'b10; pcw = 1; end
      default:    ;
    endcase
    if (!rn) begin
      irw = 0; pcw = 0; mw = 0; rw = 0; br = 0;
    end
    return {st, io, mw, irw, pcw, br, ps, ao, sa, sb, rd, mtr, rw, ill};
  endfunction

  // Drive one cycle of inputs shortly after the rising edge and queue the expected word.
  task automatic step(input string nm, input logic [5:0] op, input logic mr,
                      input logic rn, input logic [3:0] st, input logic ill);
    @(posedge clk);
    #1;
    opcode    = op;
    mem_ready = mr;
    rst_n     = rn;
    exp_q.push_back(exp_vec(st, mr, rn, ill));
    name_q.push_back(nm);
  endtask

  // Monitor: compare the DUT control word against the queued expectation mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [19:0] e, a;
      string       n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {state_dbg, iord, mem_write, ir_write, pc_write, branch, pc_src, alu_op,
           alu_src_a, alu_src_b, reg_dst, mem_to_reg, reg_write, illegal_op};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s: got %05h expected %05h (state got %0d expected %0d)",
                 n, a, e, a[19:16], e[19:16]);
      end
    end
  end

  initial begin
    // Power-on reset: FETCH selects, strobes off even with mem_ready high.
    step("rst_hold0", 6'h3F, 1, 0, 4'd0, 0);
    step("rst_hold1", 6'h3F, 1, 0, 4'd0, 0);

    // RTYPE, junk opcode during FETCH must be ignored.
    step("rt_fetch",  6'h3F, 1, 1, 4'd0, 0);
    step("rt_decode", 6'h00, 1, 1, 4'd1, 0);
    step("rt_ex",     6'h00, 1, 1, 4'd6, 0);
    step("rt_wb",     6'h00, 1, 1, 4'd7, 0);

    // LW with two stall cycles in MEMRD.
    step("lw_fetch",  6'h3F, 1, 1, 4'd0, 0);
    step("lw_decode", 6'h23, 1, 1, 4'd1, 0);
    step("lw_memadr", 6'h23, 1, 1, 4'd2, 0);
    step("lw_rd_st0", 6'h23, 0, 1, 4'd3, 0);
    step("lw_rd_st1", 6'h23, 0, 1, 4'd3, 0);
    step("lw_rd_go",  6'h23, 1, 1, 4'd3, 0);
    step("lw_wb",     6'h23, 1, 1, 4'd4, 0);

    // SW with three stall cycles in MEMWR: mem_write held four cycles.
    step("sw_fetch",  6'h3F, 1, 1, 4'd0, 0);
    step("sw_decode", 6'h2B, 1, 1, 4'd1, 0);
    step("sw_memadr", 6'h2B, 1, 1, 4'd2, 0);
    step("sw_wr_st0", 6'h2B, 0, 1, 4'd5, 0);
    step("sw_wr_st1", 6'h2B, 0, 1, 4'd5, 0);
    step("sw_wr_st2", 6'h2B, 0, 1, 4'd5, 0);
    step("sw_wr_go",  6'h2B, 1, 1, 4'd5, 0);

    // BEQ preceded by a two-cycle fetch stall.
    step("beq_f_st0", 6'h04, 0, 1, 4'd0, 0);
    step("beq_f_st1", 6'h04, 0, 1, 4'd0, 0);
    step("beq_fetch", 6'h04, 1, 1, 4'd0, 0);
    step("beq_dec",   6'h04, 1, 1, 4'd1, 0);
    step("beq_ex",    6'h04, 1, 1, 4'd8, 0);

    // J.
    step("j_fetch",   6'h3F, 1, 1, 4'd0, 0);
    step("j_decode",  6'h02, 1, 1, 4'd1, 0);
    step("j_ex",      6'h02, 1, 1, 4'd11, 0);

    // ADDI.
    step("addi_fetch", 6'h3F, 1, 1, 4'd0, 0);
    step("addi_dec",   6'h08, 1, 1, 4'd1, 0);
    step("addi_ex",    6'h08, 1, 1, 4'd9, 0);
    step("addi_wb",    6'h08, 1, 1, 4'd10, 0);

    // Illegal opcode: one-cycle flag in DECODE, then straight back to FETCH.
    step("ill_fetch",  6'h00, 1, 1, 4'd0, 0);
    step("ill_decode", 6'h3F, 1, 1, 4'd1, 1);
    step("ill_back",   6'h00, 1, 1, 4'd0, 0);

    // Reset asserted in RTYPEEX: immediate return to FETCH, strobes off.
    step("rx_decode",  6'h00, 1, 1, 4'd1, 0);
    step("rx_reset0",  6'h00, 1, 0, 4'd0, 0);
    step("rx_reset1",  6'h00, 1, 0, 4'd0, 0);
    // After release: a fresh instruction, no leftover RTYPE writeback.
    step("post_fetch", 6'h3F, 1, 1, 4'd0, 0);
    step("post_dec",   6'h08, 1, 1, 4'd1, 0);
    step("post_ex",    6'h08, 1, 1, 4'd9, 0);
    step("post_wb",    6'h08, 1, 1, 4'd10, 0);
    step("post_idle",  6'h3F, 0, 1, 4'd0, 0);

    // Drain: every queued expectation must have been consumed by the monitor.
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Multicycle MIPS control unit. Sequences each instruction through fetch, decode, execute, memory and writeback states. Drives the select lines of the datapath's 5-bit and 32-bit multiplexers (RegDst, ALUSrcA/B, MemtoReg, IorD, PCSrc) plus all write strobes. Sits directly upstream of the datapath mux/register/ALU stage and stalls on a memory-ready handshake.

## Interface
Parameters:
- MEM_WAIT_EN, 1, when 1 the memory states wait for mem_ready; when 0 mem_ready is treated as constantly 1

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  instr[31:26] from the instruction register
- mem_ready  in  1  memory has completed the current access
- iord  out  1  memory address mux select: 0 = PC, 1 = ALUOut
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction register load
- pc_write  out  1  unconditional PC load
- branch  out  1  conditional PC load, qualified by Zero in the datapath
- pc_src  out  2  PC mux select: 00 = ALU, 01 = ALUOut, 10 = jump target
- alu_op  out  2  00 = add, 01 = sub, 10 = funct-decoded
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2
- reg_dst  out  1  5-bit mux select: 0 = rt, 1 = rd
- mem_to_reg  out  1  32-bit mux select: 0 = ALUOut, 1 = MDR
- reg_write  out  1  register file write strobe
- illegal_op  out  1  unsupported opcode seen in DECODE
- state_dbg  out  4  current state encoding

## Operation
- Supported opcodes: LW 6'h23, SW 6'h2B, RTYPE 6'h00, BEQ 6'h04, ADDI 6'h08, J 6'h02.
- States and transitions:
  - FETCH: goes to DECODE when mem_ready=1, otherwise holds.
  - DECODE: LW/SW go to MEMADR; RTYPE to RTYPEEX; BEQ to BEQEX; ADDI to ADDIEX; J to JEX; any other opcode goes to FETCH.
  - MEMADR: LW goes to MEMRD, SW goes to MEMWR.
  - MEMRD: goes to MEMWB on mem_ready, otherwise holds.
  - MEMWR: goes to FETCH on mem_ready, otherwise holds.
  - MEMWB, RTYPEWB, ADDIWB, BEQEX, JEX: go to FETCH.
  - RTYPEEX goes to RTYPEWB. ADDIEX goes to ADDIWB.
- Outputs are Moore per state, with one exception: in FETCH, ir_write and pc_write equal mem_ready.
- Output values per state (unlisted outputs are 0):
  - FETCH: iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00.
  - MEMADR and ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00.
  - MEMRD: iord=1.
  - MEMWR: iord=1, mem_write=1, held for the whole state.
  - MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1.
  - RTYPEEX: alu_src_a=1, alu_src_b=00, alu_op=10.
  - RTYPEWB: reg_dst=1, mem_to_reg=0, reg_write=1.
  - ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1.
  - BEQEX: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1.
  - JEX: pc_src=10, pc_write=1.
- illegal_op is 1 only in DECODE with an unsupported opcode, for exactly one cycle.

## Timing
- Reset: state goes to FETCH asynchronously on rst_n low. While rst_n=0, all strobes (ir_write, pc_write, mem_write, reg_write, branch) are forced to 0.
- All other outputs take their FETCH values during and after reset. state_dbg=0 in FETCH.
- Cycle counts with mem_ready=1 throughout: LW 5, SW 4, RTYPE 4, ADDI 4, BEQ 3, J 3, illegal 2.
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle. No strobe is repeated during a stall, except mem_write, which stays high.
- opcode is sampled only in DECODE and MEMADR. Values at other times are ignored.
- rst_n asserted mid-instruction aborts it immediately. No partial writeback is issued after reset release.

## Structure
- Package mips_ctrl_pkg holds:
  - the state enum (4-bit: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11);
  - opcode localparams;
  - ALUOp, ALUSrcB and PCSrc encodings.
- Sub-module mips_ctrl_outdec: purely combinational, maps state plus mem_ready to the output vector. The top holds only the state register and next-state logic.

## Test plan
- Reset: rst_n=0 mid-RTYPEEX → state_dbg=0 and all strobes 0 immediately. After release, FETCH with alu_src_b=01.
- RTYPE, mem_ready=1: opcode 6'h00 → states 0,1,6,7,0. reg_dst=1 and reg_write=1 only in cycle 4.
- LW with a 2-cycle stall in MEMRD: opcode 6'h23 → states 0,1,2,3,3,3,4. mem_to_reg=1, reg_write=1 once.
- SW with mem_ready low for 3 cycles in MEMWR → mem_write=1 for 4 cycles, then FETCH. reg_write is never set.
- BEQ and J: 6'h04 → branch=1, pc_src=01 in cycle 3. 6'h02 → pc_write=1, pc_src=10 in cycle 3.
- Illegal opcode 6'h3F → illegal_op=1 for one cycle in DECODE, then FETCH. No strobes are asserted.
